// File: rtl/bnn_if_pkg.sv
// Shared types and default parameters for the BNN core bridge.
// Latency: none (package only).
// Backpressure: not applicable.
package bnn_if_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    RETURN = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } bridge_state_t;

  localparam int unsigned DEF_IMG_W       = 900;
  localparam int unsigned DEF_PAD_W       = 4;
  localparam int unsigned DEF_RES_W       = 4;
  localparam int unsigned DEF_CE_DIV      = 4;
  localparam int unsigned DEF_SYNC_STAGES = 3;
  localparam int unsigned DEF_TIMEOUT_TCK = 4096;
  localparam int unsigned DEF_CNT_W       = 16;

  // Larger of two unsigned values, used to size the shared tick counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bnn_ce_gen.sv
// Clock-enable generator: one-clk pulse every CE_DIV clks, first clk after reset is a tick.
// Latency: enable is combinational from the divider register; held low while in reset.
// Backpressure: none, free-running.
module bnn_ce_gen #(
  parameter int unsigned CE_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic core_clk_en
);

  localparam int unsigned DW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  // Next divider value: wrap to zero after CE_DIV-1 (stays 0 when CE_DIV is 1).
  always_comb begin
    div_d = div_q + DW'(1);
    if (div_q == DW'(CE_DIV - 1)) begin
      div_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Gated by rst_n so the enable reads 0 while reset is held.
  assign core_clk_en = rst_n && (div_q == '0);

endmodule

// File: rtl/bnn_core_bridge.sv
// Handshake bridge: snapshots an image, launches the BNN core on the enable grid, returns result.
// Latency: SYNC_STAGES ticks to launch, core time (<= TIMEOUT_TCK ticks), SYNC_STAGES ticks to return.
// Backpressure: result/error held until bnn_clear; new images ignored until back in IDLE.
module bnn_core_bridge
  import bnn_if_pkg::*;
#(
  parameter int unsigned IMG_W       = DEF_IMG_W,
  parameter int unsigned PAD_W       = DEF_PAD_W,
  parameter int unsigned RES_W       = DEF_RES_W,
  parameter int unsigned CE_DIV      = DEF_CE_DIV,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT_TCK = DEF_TIMEOUT_TCK,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IMG_W+PAD_W-1:0] img_in,
  input  logic                   img_buffer_full,
  input  logic                   bnn_enable,
  input  logic                   bnn_clear,
  output logic [RES_W-1:0]       result_out,
  output logic                   result_ready,
  output logic                   bnn_error,
  output logic                   bnn_busy,
  output logic [CNT_W-1:0]       infer_count,
  output logic                   core_clk_en,
  output logic [IMG_W-1:0]       core_img,
  output logic                   core_start,
  input  logic [RES_W-1:0]       core_result,
  input  logic                   core_done
);

  localparam int unsigned CW = $clog2(max_u(SYNC_STAGES, TIMEOUT_TCK) + 1);

  bridge_state_t    state_q, state_d;
  logic [CW-1:0]    tick_q, tick_d;
  logic [IMG_W-1:0] img_q, img_d;
  logic             start_q, start_d;
  logic [RES_W-1:0] held_q, held_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ce;

  // Pad bits of the image are deliberately dropped.
  logic unused_pad;
  assign unused_pad = ^img_in[PAD_W-1:0];

  bnn_ce_gen #(.CE_DIV(CE_DIV)) u_ce_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_clk_en (ce)
  );

  // Next-state and datapath: clear/start act every clk, core-side progress only on ticks.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    img_d   = img_q;
    start_d = start_q;
    held_d  = held_q;
    res_d   = res_q;
    ready_d = ready_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // Clear wins over a simultaneous start request.
        if (!bnn_clear && img_buffer_full && bnn_enable) begin
          img_d   = img_in[IMG_W+PAD_W-1:PAD_W];
          tick_d  = '0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (bnn_clear) begin
          start_d = 1'b0;
          tick_d  = '0;
          state_d = IDLE;
        end else if (ce) begin
          if (tick_q == CW'(SYNC_STAGES - 1)) begin
            start_d = 1'b1;
            tick_d  = '0;
            state_d = RUN;
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
      end
      RUN: begin
        if (bnn_clear) begin
          start_d = 1'b0;
          tick_d  = '0;
          state_d = IDLE;
        end else if (ce) begin
          // Start strobe lasts exactly one enable period.
          start_d = 1'b0;
          if (core_done) begin
            // Done takes priority over a timeout expiring on the same tick.
            held_d  = core_result;
            tick_d  = '0;
            state_d = RETURN;
          end else if (tick_q == CW'(TIMEOUT_TCK - 1)) begin
            err_d   = 1'b1;
            tick_d  = '0;
            state_d = ERROR;
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
      end
      RETURN: begin
        if (bnn_clear) begin
          tick_d  = '0;
          state_d = IDLE;
        end else if (ce) begin
          if (tick_q == CW'(SYNC_STAGES - 1)) begin
            res_d   = held_q;
            ready_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            tick_d  = '0;
            state_d = DONE;
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
      end
      DONE, ERROR: begin
        if (bnn_clear) begin
          ready_d = 1'b0;
          err_d   = 1'b0;
          tick_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        tick_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      img_q   <= '0;
      start_q <= 1'b0;
      held_q  <= '0;
      res_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      img_q   <= img_d;
      start_q <= start_d;
      held_q  <= held_d;
      res_q   <= res_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign result_out   = res_q;
  assign result_ready = ready_q;
  assign bnn_error    = err_q;
  assign bnn_busy     = (state_q == LAUNCH) || (state_q == RUN) || (state_q == RETURN);
  assign infer_count  = cnt_q;
  assign core_clk_en  = ce;
  assign core_img     = img_q;
  assign core_start   = start_q;

endmodule

// File: tb/tb_bnn_core_bridge.sv
// Bench for bnn_core_bridge: timestamp-based model checked every clk, plus literal expectations.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: mock core answers on the enable grid; every wait is bounded.
`timescale 1ns/1ps
module tb_bnn_core_bridge;

  localparam int SYNC = 3;
  localparam int TO   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [903:0] img_in;
  logic         full, en, clear, core_done;
  logic [3:0]   core_result;

  logic [3:0]   r0, r1;
  logic         rdy0, rdy1, err0, err1, busy0, busy1, ce0, ce1, st0, st1;
  logic [15:0]  cnt0, cnt1;
  logic [899:0] img0, img1;

  bnn_core_bridge #(.CE_DIV(4), .SYNC_STAGES(SYNC), .TIMEOUT_TCK(TO)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .img_in(img_in), .img_buffer_full(full), .bnn_enable(en),
    .bnn_clear(clear), .result_out(r0), .result_ready(rdy0), .bnn_error(err0), .bnn_busy(busy0),
    .infer_count(cnt0), .core_clk_en(ce0), .core_img(img0), .core_start(st0),
    .core_result(core_result), .core_done(core_done));

  bnn_core_bridge #(.CE_DIV(1), .SYNC_STAGES(SYNC), .TIMEOUT_TCK(TO)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .img_in(img_in), .img_buffer_full(full), .bnn_enable(en),
    .bnn_clear(clear), .result_out(r1), .result_ready(rdy1), .bnn_error(err1), .bnn_busy(busy1),
    .infer_count(cnt1), .core_clk_en(ce1), .core_img(img1), .core_start(st1),
    .core_result(core_result), .core_done(core_done));

  // Selected instance under check; switched only while reset is held.
  logic sel;
  int   ce_div;
  logic [3:0]   d_res;
  logic         d_rdy, d_err, d_busy, d_ce, d_st;
  logic [15:0]  d_cnt;
  logic [899:0] d_img;
  assign d_res  = sel ? r1 : r0;
  assign d_rdy  = sel ? rdy1 : rdy0;
  assign d_err  = sel ? err1 : err0;
  assign d_busy = sel ? busy1 : busy0;
  assign d_ce   = sel ? ce1 : ce0;
  assign d_st   = sel ? st1 : st0;
  assign d_cnt  = sel ? cnt1 : cnt0;
  assign d_img  = sel ? img1 : img0;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: edges after reset release are numbered; events are placed by edge number.
  int           n_edge;
  logic         m_job, m_ready, m_err, m_start;
  logic [3:0]   m_res, m_held;
  logic [15:0]  m_cnt;
  logic [899:0] m_img;
  int           start_edge, done_edge;

  task automatic check(input string nm, input logic [449:0] act, input logic [449:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic is_tick(input int e);
    return (e % ce_div) == 0;
  endfunction

  task automatic model_reset();
    n_edge = 0; m_job = 0; m_ready = 0; m_err = 0; m_start = 0;
    m_res = '0; m_held = '0; m_cnt = '0; m_img = '0; start_edge = -1; done_edge = -1;
  endtask

  task automatic model_edge();
    int n;
    n = n_edge;
    if (!m_job) begin
      if (m_ready || m_err) begin
        if (clear) begin m_ready = 0; m_err = 0; end
      end else if (!clear && full && en) begin
        m_job      = 1;
        m_img      = img_in[903:4];
        start_edge = ((n / ce_div) + 1) * ce_div + (SYNC - 1) * ce_div;
        done_edge  = -1;
      end
    end else if (clear) begin
      m_job = 0; m_start = 0;
    end else begin
      if (n == start_edge) m_start = 1;
      if (n == start_edge + ce_div) m_start = 0;
      if (done_edge < 0 && core_done && is_tick(n) && n > start_edge &&
          n <= start_edge + TO * ce_div) begin
        done_edge = n; m_held = core_result;
      end
      if (done_edge >= 0 && n == done_edge + SYNC * ce_div) begin
        m_res = m_held; m_ready = 1; m_cnt = m_cnt + 16'd1; m_job = 0;
      end else if (done_edge < 0 && n == start_edge + TO * ce_div) begin
        m_err = 1; m_job = 0;
      end
    end
  endtask

  // One clk: advance the model on the edge, then compare every output 1 ns later.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      #1;
    end else begin
      model_edge();
      n_edge++;
      #1;
      check("m_result_out", d_res, m_res);
      check("m_result_ready", d_rdy, m_ready);
      check("m_bnn_error", d_err, m_err);
      check("m_bnn_busy", d_busy, m_job);
      check("m_infer_count", d_cnt, m_cnt);
      check("m_core_start", d_st, m_start);
      check("m_core_clk_en", d_ce, is_tick(n_edge));
      check("m_core_img_hi", d_img[899:450], m_img[899:450]);
      check("m_core_img_lo", d_img[449:0], m_img[449:0]);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) step();
  endtask

  task automatic start_job();
    full = 1; en = 1;
    step();
    full = 0; en = 0;
  endtask

  // Step until the chosen output rises; returns the number of enable ticks that elapsed.
  task automatic wait_out(input string nm, input int which, output int ticks);
    logic hit;
    hit = 0;
    ticks = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (d_ce) ticks++;
      step();
      case (which)
        0: hit = d_st;
        1: hit = d_rdy;
        default: hit = d_err;
      endcase
    end
    if (!hit) check({nm, "_timeout"}, hit, 1);
  endtask

  task automatic mock_done(input int delay_ticks, input logic [3:0] res);
    cycles(delay_ticks * ce_div);
    core_done = 1; core_result = res;
    cycles(ce_div);
    core_done = 0; core_result = '0;
  endtask

  task automatic do_clear();
    clear = 1;
    step();
    clear = 0;
  endtask

  int           t;
  logic [903:0] pat;
  logic [899:0] exp_img;

  initial begin
    rst_n = 0; img_in = '0; full = 0; en = 0; clear = 0; core_done = 0; core_result = '0;
    sel = 0; ce_div = 4;
    model_reset();
    cycles(3);
    check("rst_result_ready", d_rdy, 0);
    check("rst_bnn_busy", d_busy, 0);
    check("rst_core_clk_en", d_ce, 0);
    check("rst_infer_count", d_cnt, 0);
    rst_n = 1;

    // Capture, launch delay and a normal result.
    cycles(2);
    pat     = {{224{4'hC}}, 4'hF, 4'h5};
    exp_img = {{224{4'hC}}, 4'hF};
    img_in  = pat;
    start_job();
    check("cap_img_hi", d_img[899:450], exp_img[899:450]);
    check("cap_img_lo", d_img[449:0], exp_img[449:0]);
    check("cap_busy", d_busy, 1);
    wait_out("start", 0, t);
    check("launch_ticks", t, 3);
    mock_done(1, 4'd7);
    wait_out("ready", 1, t);
    check("return_ticks", t, 3);
    check("res_7", d_res, 7);
    check("count_1", d_cnt, 1);
    check("no_err", d_err, 0);
    do_clear();
    check("clr_ready", d_rdy, 0);
    check("clr_busy", d_busy, 0);
    check("res_retained", d_res, 7);

    // Timeout with no core_done.
    start_job();
    wait_out("start2", 0, t);
    wait_out("err", 2, t);
    check("timeout_ticks", t, 8);
    check("to_ready", d_rdy, 0);
    check("to_busy", d_busy, 0);
    do_clear();
    check("to_clr_err", d_err, 0);
    check("to_clr_busy", d_busy, 0);

    // core_done on the expiry tick is accepted.
    start_job();
    wait_out("start3", 0, t);
    mock_done(7, 4'd9);
    wait_out("ready3", 1, t);
    check("exp_res_9", d_res, 9);
    check("exp_no_err", d_err, 0);
    check("exp_count_2", d_cnt, 2);
    do_clear();

    // Clear beats start, then abort during RUN.
    full = 1; en = 1; clear = 1;
    step();
    full = 0; en = 0; clear = 0;
    check("clr_beats_start", d_busy, 0);
    start_job();
    wait_out("start4", 0, t);
    cycles(ce_div);
    do_clear();
    check("abort_busy", d_busy, 0);
    check("abort_start", d_st, 0);
    core_done = 1; core_result = 4'd5;
    cycles(3 * ce_div);
    core_done = 0; core_result = '0;
    cycles(4 * ce_div);
    check("abort_ready", d_rdy, 0);
    check("abort_count", d_cnt, 2);

    // Reset asserted during RETURN.
    start_job();
    wait_out("start5", 0, t);
    mock_done(1, 4'd7);
    cycles(ce_div);
    check("in_return_busy", d_busy, 1);
    rst_n = 0;
    #1;
    check("arst_res", d_res, 0);
    check("arst_ready", d_rdy, 0);
    check("arst_err", d_err, 0);
    check("arst_busy", d_busy, 0);
    check("arst_count", d_cnt, 0);
    check("arst_ce", d_ce, 0);
    check("arst_start", d_st, 0);
    check("arst_img", d_img[449:0], 0);
    cycles(2);
    sel = 1; ce_div = 1;
    rst_n = 1;

    // Normal result with an enable on every clk.
    cycles(2);
    start_job();
    wait_out("start6", 0, t);
    check("ce1_launch_ticks", t, 3);
    mock_done(1, 4'd7);
    wait_out("ready6", 1, t);
    check("ce1_return_ticks", t, 3);
    check("ce1_res_7", d_res, 7);
    check("ce1_count_1", d_cnt, 1);
    do_clear();
    check("ce1_clr_busy", d_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
